// File: rtl/div_nbit_sr_if.sv
// Divider request/result bundle shared by the MultDiv
// unit and the divider core.
interface div_nbit_sr_if #(
  parameter int WIDTH = 32
);
  logic             ctrl_DIV;
  logic             ctrl_signed;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic [WIDTH-1:0] data_remainder;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_DIV,
    output ctrl_signed,
    output data_operandA,
    output data_operandB,
    input  data_result,
    input  data_remainder,
    input  data_exception,
    input  data_resultRDY,
    input  busy
  );

  modport slave (
    input  ctrl_DIV,
    input  ctrl_signed,
    input  data_operandA,
    input  data_operandB,
    output data_result,
    output data_remainder,
    output data_exception,
    output data_resultRDY,
    output busy
  );
endinterface

// File: rtl/div_nbit_sr.sv
// Multi-cycle non-restoring divider, signed/unsigned,
// one quotient bit per cycle with a final fix-up step.
module div_nbit_sr #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 7
) (
  input logic         clock,
  input logic         reset,
  div_nbit_sr_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, RUN, FIX, DONE
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             qs_q, qs_d;
  logic             rs_q, rs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   p_sh, p_step;
  logic [WIDTH-1:0] r_mag, q_fin, r_fin;
  logic             last;

  assign a_neg = bus.ctrl_signed
               & bus.data_operandA[WIDTH-1];
  assign b_neg = bus.ctrl_signed
               & bus.data_operandB[WIDTH-1];
  assign a_abs = a_neg ? -bus.data_operandA
                       : bus.data_operandA;
  assign b_abs = b_neg ? -bus.data_operandB
                       : bus.data_operandB;

  // Upper half is WIDTH+1 wide so |A| = 2^(WIDTH-1) fits.
  assign p_sh   = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign p_step = p_q[WIDTH] ? p_sh + {1'b0, d_q}
                             : p_sh - {1'b0, d_q};
  assign r_mag  = p_q[WIDTH] ? p_q[WIDTH-1:0] + d_q
                             : p_q[WIDTH-1:0];
  assign q_fin  = qs_q ? -q_q : q_q;
  assign r_fin  = rs_q ? -r_mag : r_mag;
  assign last   = cnt_q == CNT_W'(WIDTH - 1);

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    q_d     = q_q;
    d_d     = d_q;
    qs_d    = qs_q;
    rs_d    = rs_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    rem_d   = rem_q;
    exc_d   = exc_q;
    rdy_d   = 1'b0;
    busy_d  = 1'b0;
    if (bus.ctrl_DIV) begin
      cnt_d = '0;
      if (bus.data_operandB == '0) begin
        state_d = DONE;
        res_d   = '1;
        rem_d   = bus.data_operandA;
        exc_d   = 1'b1;
        rdy_d   = 1'b1;
      end else begin
        state_d = RUN;
        p_d     = '0;
        q_d     = a_abs;
        d_d     = b_abs;
        qs_d    = a_neg ^ b_neg;
        rs_d    = a_neg;
        exc_d   = 1'b0;
        busy_d  = 1'b1;
      end
    end else begin
      unique case (state_q)
        RUN: begin
          p_d    = p_step;
          q_d    = {q_q[WIDTH-2:0], ~p_step[WIDTH]};
          cnt_d  = cnt_q + CNT_W'(1);
          busy_d = 1'b1;
          if (last) state_d = FIX;
        end
        FIX: begin
          res_d   = q_fin;
          rem_d   = r_fin;
          rdy_d   = 1'b1;
          state_d = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      p_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      qs_q    <= 1'b0;
      rs_q    <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      rem_q   <= '0;
      exc_q   <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      q_q     <= q_d;
      d_q     <= d_d;
      qs_q    <= qs_d;
      rs_q    <= rs_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      rem_q   <= rem_d;
      exc_q   <= exc_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.data_result    = res_q;
  assign bus.data_remainder = rem_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = busy_q;
endmodule

// File: tb/tb_div_nbit_sr.sv
// Directed bench for div_nbit_sr: 32-bit and 8-bit
// instances driven through their request interfaces.
module tb_div_nbit_sr;
  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  div_nbit_sr_if #(.WIDTH(32)) b32 ();
  div_nbit_sr_if #(.WIDTH(8))  b8 ();

  div_nbit_sr #(.WIDTH(32), .CNT_W(7)) u32 (
    .clock (clock),
    .reset (reset),
    .bus   (b32.slave)
  );

  div_nbit_sr #(.WIDTH(8), .CNT_W(4)) u8 (
    .clock (clock),
    .reset (reset),
    .bus   (b8.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic run(input bit w8,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input bit sgn,
                     output int lat,
                     output int bsy);
    @(negedge clock);
    if (w8) begin
      b8.ctrl_DIV      = 1'b1;
      b8.ctrl_signed   = sgn;
      b8.data_operandA = a[7:0];
      b8.data_operandB = b[7:0];
    end else begin
      b32.ctrl_DIV      = 1'b1;
      b32.ctrl_signed   = sgn;
      b32.data_operandA = a;
      b32.data_operandB = b;
    end
    @(negedge clock);
    b8.ctrl_DIV  = 1'b0;
    b32.ctrl_DIV = 1'b0;
    lat = 0;
    bsy = 0;
    for (int n = 1; n <= 100; n++) begin
      if (w8 ? b8.busy : b32.busy) bsy++;
      if (w8 ? b8.data_resultRDY
             : b32.data_resultRDY) begin
        lat = n;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic start32(input logic [31:0] a,
                         input logic [31:0] b);
    b32.ctrl_DIV      = 1'b1;
    b32.ctrl_signed   = 1'b0;
    b32.data_operandA = a;
    b32.data_operandB = b;
  endtask

  int lat, bsy, rdy_cnt, rdy_at;
  logic [31:0] q_cap, r_cap;

  initial begin
    b32.ctrl_DIV = 0; b32.ctrl_signed = 0;
    b32.data_operandA = 0; b32.data_operandB = 0;
    b8.ctrl_DIV = 0; b8.ctrl_signed = 0;
    b8.data_operandA = 0; b8.data_operandB = 0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    check("rst_q",    b32.data_result, 0);
    check("rst_r",    b32.data_remainder, 0);
    check("rst_exc",  b32.data_exception, 0);
    check("rst_rdy",  b32.data_resultRDY, 0);
    check("rst_busy", b32.busy, 0);

    run(0, 100, 7, 0, lat, bsy);
    check("u100_lat",  lat, 34);
    check("u100_busy", bsy, 33);
    check("u100_q",    b32.data_result, 14);
    check("u100_r",    b32.data_remainder, 2);
    check("u100_exc",  b32.data_exception, 0);

    run(0, -32'sd7, 2, 1, lat, bsy);
    check("sm7_q", b32.data_result, 32'hFFFF_FFFD);
    check("sm7_r", b32.data_remainder, 32'hFFFF_FFFF);

    run(0, 7, -32'sd2, 1, lat, bsy);
    check("s7m2_q", b32.data_result, 32'hFFFF_FFFD);
    check("s7m2_r", b32.data_remainder, 1);

    run(0, 32'hFFFF_FFFF, 1, 0, lat, bsy);
    check("umax_q", b32.data_result, 32'hFFFF_FFFF);
    check("umax_r", b32.data_remainder, 0);

    run(0, 32'h1234, 0, 0, lat, bsy);
    check("dz_lat", lat, 1);
    check("dz_exc", b32.data_exception, 1);
    check("dz_q",   b32.data_result, 32'hFFFF_FFFF);
    check("dz_r",   b32.data_remainder, 32'h1234);

    run(0, 32'h1234, 3, 0, lat, bsy);
    check("dz2_exc", b32.data_exception, 0);
    check("dz2_q",   b32.data_result, 32'h611);
    check("dz2_r",   b32.data_remainder, 1);

    run(0, 32'h8000_0000, 32'hFFFF_FFFF, 1,
        lat, bsy);
    check("ovf_q",   b32.data_result, 32'h8000_0000);
    check("ovf_r",   b32.data_remainder, 0);
    check("ovf_exc", b32.data_exception, 0);

    // restart mid-run: only the second op completes
    @(negedge clock);
    start32(100, 7);
    @(negedge clock);
    b32.ctrl_DIV = 1'b0;
    rdy_cnt = 0;
    rdy_at  = 0;
    q_cap   = 0;
    r_cap   = 0;
    for (int n = 1; n <= 60; n++) begin
      if (b32.data_resultRDY) begin
        rdy_cnt++;
        if (rdy_at == 0) begin
          rdy_at = n;
          q_cap  = b32.data_result;
          r_cap  = b32.data_remainder;
        end
      end
      if (n == 10) start32(50, 5);
      if (n == 11) b32.ctrl_DIV = 1'b0;
      @(negedge clock);
    end
    check("rs_cnt", rdy_cnt, 1);
    check("rs_at",  rdy_at, 44);
    check("rs_q",   q_cap, 10);
    check("rs_r",   r_cap, 0);

    // synchronous reset in the middle of a run
    start32(100, 7);
    @(negedge clock);
    b32.ctrl_DIV = 1'b0;
    repeat (4) @(negedge clock);
    check("mr_busy5", b32.busy, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mr_q",    b32.data_result, 0);
    check("mr_r",    b32.data_remainder, 0);
    check("mr_exc",  b32.data_exception, 0);
    check("mr_busy", b32.busy, 0);
    rdy_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      if (b32.data_resultRDY) rdy_cnt++;
      @(negedge clock);
    end
    check("mr_nordy", rdy_cnt, 0);

    run(1, 255, 16, 0, lat, bsy);
    check("w8u_lat", lat, 10);
    check("w8u_q",   b8.data_result, 15);
    check("w8u_r",   b8.data_remainder, 15);

    run(1, 32'h80, 3, 1, lat, bsy);
    check("w8s_lat", lat, 10);
    check("w8s_q",   b8.data_result, 8'hD6);
    check("w8s_r",   b8.data_remainder, 8'hFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/div_nbit_sr.md
Name: div_nbit_sr

Overview:
Parametrised, multi-cycle, non-restoring integer divider; next generation of the 32-bit multdiv divider.
Adds width parameter, signed/unsigned mode, remainder output, busy flag, a registered result-ready pulse, and defined results for divide-by-zero and signed overflow.
Sits in the MultDiv unit beside the multiplier; the pipeline stalls on busy and captures outputs on data_resultRDY.

Parameters:
WIDTH, 32, operand/result width in bits (supported 4..64).
CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > WIDTH+1.

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
ctrl_DIV  in  1  start pulse; samples operands and ctrl_signed this cycle
ctrl_signed  in  1  1 = two's-complement divide, 0 = unsigned
data_operandA  in  WIDTH  dividend
data_operandB  in  WIDTH  divisor
data_result  out  WIDTH  quotient, registered
data_remainder  out  WIDTH  remainder, registered
data_exception  out  1  divide-by-zero flag, registered
data_resultRDY  out  1  one-cycle pulse: outputs valid
busy  out  1  high while an operation is in flight

Behaviour:
- Reset (reset=1 at edge): state IDLE; data_result, data_remainder, counter = 0; data_exception, data_resultRDY, busy = 0. Overrides ctrl_DIV in the same cycle.
- States: IDLE, RUN, FIX, DONE.
- IDLE + ctrl_DIV:
  - Latch |A|, |B| (abs only when ctrl_signed=1), quotient sign = A[MSB]^B[MSB], remainder sign = A[MSB] (signed mode only).
  - Clear the 2*WIDTH-bit remainder/quotient register and counter. Go to RUN.
- Start with B==0: go directly to DONE. Quotient = all ones; remainder = A unmodified; data_exception = 1.
- RUN, one iteration per cycle, WIDTH cycles:
  - Shift RQ left by 1.
  - Upper half += divisor if the prior upper half is negative, else -= divisor.
  - Quotient LSB = ~sign of the new upper half. Counter increments.
  - Leave RUN after iteration WIDTH.
- Width rule: the upper/remainder datapath is WIDTH+1 bits so the MSB of |A| = 2^(WIDTH-1) never overflows.
- FIX, 1 cycle:
  - If the remainder is negative, add the divisor (restore).
  - Apply sign correction: negate the quotient if quotient sign = 1; negate the remainder if remainder sign = 1.
  - Write data_result/data_remainder. Go to DONE.
- DONE, 1 cycle: data_resultRDY = 1, busy = 0. Go to IDLE.
- Latency:
  - Normal: start edge to RDY-high cycle = WIDTH+2 cycles (34 for WIDTH=32).
  - Divide-by-zero: 1 cycle.
- busy: 1 from the cycle after start through FIX; 0 in IDLE and DONE.
- Outputs hold their last values in IDLE until the next start's DONE. data_exception is cleared at the next start.
- Signed overflow (A = most negative, B = -1, ctrl_signed=1): falls out naturally; quotient = most negative, remainder = 0, data_exception = 0.
- ctrl_DIV while busy (RUN/FIX): abort and restart with the new operands; the aborted operation never raises RDY.
- ctrl_DIV in DONE: RDY still pulses this cycle; the new operation starts.
- Unsigned mode: operands are never negated; quotient and remainder signs are forced 0.
- Invariant (B≠0): A = Q*B + R, |R| < |B|, R sign = A sign or R = 0.

Test Plan:
- Unsigned, WIDTH=32: A=100, B=7 -> RDY exactly 34 cycles after start; Q=14, R=2; exception=0; busy high for 33 cycles.
- Signed: A=-7, B=2 -> Q=-3 (0xFFFFFFFD), R=-1.
- Signed: A=7, B=-2 -> Q=-3, R=1.
- Unsigned: A=0xFFFFFFFF, B=1 -> Q=0xFFFFFFFF, R=0.
- Divide-by-zero: A=0x1234, B=0 -> RDY 1 cycle after start; exception=1; Q=0xFFFFFFFF, R=0x1234. Next start with B=3 clears exception.
- Overflow: A=0x80000000, B=0xFFFFFFFF, signed -> Q=0x80000000, R=0, exception=0.
- Restart/reset:
  - Start 100/7; at cycle 10 start 50/5 -> single RDY at cycle 10+34 with Q=10, R=0.
  - Assert reset at cycle 5 of a run -> all outputs 0 next cycle, no RDY.
- WIDTH=8 instance, unsigned: A=255, B=16 -> Q=15, R=15, RDY at cycle 10. Repeat signed with A=-128, B=3 -> Q=-42, R=-2.
